// File: rtl/accelerator_tensor_stream_transmitter.sv
// Buffers upstream words in a small FIFO and replays them as a row-major I/J/K tensor stream.
// Optional DATA_OUT_LAST port is enabled by defining ACCELERATOR_TENSOR_STREAM_TRANSMITTER_LAST_EN.
module accelerator_tensor_stream_transmitter #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] SIZE_K_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    input  logic                 DATA_IN_VALID,
    output logic                 DATA_IN_READY,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 DATA_OUT_I_ENABLE,
    output logic                 DATA_OUT_J_ENABLE,
    output logic                 DATA_OUT_K_ENABLE
`ifdef ACCELERATOR_TENSOR_STREAM_TRANSMITTER_LAST_EN
    ,
    output logic                 DATA_OUT_LAST
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        ENDER
    } state_t;

    state_t state_q, state_d;

    logic [CONTROL_SIZE-1:0] size_i, size_j, size_k;
    logic [CONTROL_SIZE-1:0] start_i, start_j, start_k;
    logic [CONTROL_SIZE-1:0] in_i, in_j, in_k;
    logic [CONTROL_SIZE-1:0] out_i, out_j, out_k;
    logic                    in_done;

    logic [DATA_SIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic push, pop, start_ok, start_zero;
    logic in_k_last, in_j_last, in_i_last;
    logic out_k_last, out_j_last, out_i_last, out_final;

    assign start_i    = CONTROL_SIZE'(SIZE_I_IN);
    assign start_j    = CONTROL_SIZE'(SIZE_J_IN);
    assign start_k    = CONTROL_SIZE'(SIZE_K_IN);
    assign start_ok   = (state_q == IDLE) && START;
    assign start_zero = (start_i == '0) || (start_j == '0) || (start_k == '0);

    assign in_k_last  = in_k == size_k - CONTROL_SIZE'(1);
    assign in_j_last  = in_j == size_j - CONTROL_SIZE'(1);
    assign in_i_last  = in_i == size_i - CONTROL_SIZE'(1);
    assign out_k_last = out_k == size_k - CONTROL_SIZE'(1);
    assign out_j_last = out_j == size_j - CONTROL_SIZE'(1);
    assign out_i_last = out_i == size_i - CONTROL_SIZE'(1);
    assign out_final  = out_i_last && out_j_last && out_k_last;

    // Ready uses the registered count, so a full FIFO stays closed even while popping.
    assign DATA_IN_READY = (state_q == STREAM) && (count != CNT_W'(FIFO_DEPTH)) && !in_done;
    assign push          = DATA_IN_VALID && DATA_IN_READY;
    assign pop           = (state_q == STREAM) && (count != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = start_zero ? ENDER : STREAM;
            STREAM:  if (pop && out_final) state_d = ENDER;
            ENDER:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            size_i  <= '0;
            size_j  <= '0;
            size_k  <= '0;
            in_i    <= '0;
            in_j    <= '0;
            in_k    <= '0;
            in_done <= 1'b0;
            out_i   <= '0;
            out_j   <= '0;
            out_k   <= '0;
        end else if (start_ok) begin
            size_i  <= start_i;
            size_j  <= start_j;
            size_k  <= start_k;
            in_i    <= '0;
            in_j    <= '0;
            in_k    <= '0;
            in_done <= 1'b0;
            out_i   <= '0;
            out_j   <= '0;
            out_k   <= '0;
        end else begin
            if (push) begin
                if (in_k_last) begin
                    in_k <= '0;
                    if (in_j_last) begin
                        in_j <= '0;
                        if (in_i_last) in_done <= 1'b1;
                        else           in_i    <= in_i + CONTROL_SIZE'(1);
                    end else begin
                        in_j <= in_j + CONTROL_SIZE'(1);
                    end
                end else begin
                    in_k <= in_k + CONTROL_SIZE'(1);
                end
            end
            if (pop) begin
                if (out_k_last) begin
                    out_k <= '0;
                    if (out_j_last) begin
                        out_j <= '0;
                        out_i <= out_i_last ? '0 : out_i + CONTROL_SIZE'(1);
                    end else begin
                        out_j <= out_j + CONTROL_SIZE'(1);
                    end
                end else begin
                    out_k <= out_k + CONTROL_SIZE'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= DATA_IN;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            READY             <= 1'b0;
            DATA_OUT          <= '0;
            DATA_OUT_I_ENABLE <= 1'b0;
            DATA_OUT_J_ENABLE <= 1'b0;
            DATA_OUT_K_ENABLE <= 1'b0;
        end else begin
            READY             <= state_q == ENDER;
            DATA_OUT_K_ENABLE <= pop;
            DATA_OUT_J_ENABLE <= pop && (out_k == '0);
            DATA_OUT_I_ENABLE <= pop && (out_k == '0) && (out_j == '0);
            if (pop) DATA_OUT <= fifo_mem[rd_ptr];
        end
    end

`ifdef ACCELERATOR_TENSOR_STREAM_TRANSMITTER_LAST_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) DATA_OUT_LAST <= 1'b0;
        else      DATA_OUT_LAST <= pop && out_final;
    end
`endif

endmodule
